// File: rtl/audio_pkg.sv
// Shared definitions for the audio FIFO / I2S serializer slice: sample width,
// saturation limits, serializer states and the saturating narrowing helper.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic signed [31:0] SAT_MAX = 32'sd32767;
    localparam logic signed [31:0] SAT_MIN = -32'sd32768;

    typedef logic [1:0] ser_state_t;

    localparam ser_state_t ST_IDLE  = 2'd0;
    localparam ser_state_t ST_DELAY = 2'd1;
    localparam ser_state_t ST_SHIFT = 2'd2;
    localparam ser_state_t ST_PAD   = 2'd3;

    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [31:0] i_val);
        logic [SAMPLE_W-1:0] w_res;
        if (i_val > SAT_MAX) begin
            w_res = SAT_MAX[SAMPLE_W-1:0];
        end else if (i_val < SAT_MIN) begin
            w_res = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            w_res = i_val[SAMPLE_W-1:0];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/audio_fifo_i2s_if.sv
// Bundle of the synth-core push side, codec I2S pins and status flags.
// The block itself connects through the slave modport.
interface audio_fifo_i2s_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

    logic               LD_FIFO;
    logic [31:0]        TONE;
    logic               FIFO_FULL;
    logic [LEVEL_W-1:0] LEVEL;
    logic               AUD_BCLK;
    logic               AUD_DACLRCK;
    logic               AUD_DACDAT;
    logic               UNDERRUN;
    logic               OVERFLOW;
    logic               CLR_STATUS;

    modport master (
        output LD_FIFO, TONE, AUD_BCLK, AUD_DACLRCK, CLR_STATUS,
        input  FIFO_FULL, LEVEL, AUD_DACDAT, UNDERRUN, OVERFLOW
    );

    modport slave (
        input  LD_FIFO, TONE, AUD_BCLK, AUD_DACLRCK, CLR_STATUS,
        output FIFO_FULL, LEVEL, AUD_DACDAT, UNDERRUN, OVERFLOW
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered level/full; a push into a full FIFO is
// accepted only when a real pop happens in the same cycle.
module sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_full;

    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [LW-1:0]    w_level_nxt;

    assign w_empty     = (r_level == '0);
    assign w_pop_ok    = i_pop & ~w_empty;
    assign w_push_ok   = i_push & (~r_full | w_pop_ok);
    assign w_level_nxt = r_level + LW'(w_push_ok) - LW'(w_pop_ok);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (w_push_ok) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata    = r_mem[r_rptr];
    assign o_full     = r_full;
    assign o_empty    = w_empty;
    assign o_level    = r_level;
    assign o_overflow = i_push & ~w_push_ok;

endmodule

// File: rtl/audio_fifo_i2s.sv
// Sample FIFO feeding a mono I2S transmitter slaved to the codec's BCLK/LRCK;
// each frame pops one sample and sends it on both channels.
module audio_fifo_i2s
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SHIFT = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    audio_fifo_i2s_if.slave   bus
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [1:0]           r_bclk_sync;
    logic [1:0]           r_lrck_sync;
    logic                 r_bclk_prev;
    logic                 r_lrck_prev;

    ser_state_t           r_state;
    logic [SAMPLE_W-1:0]  r_shift;
    logic [SAMPLE_W-1:0]  r_held;
    logic [4:0]           r_cnt;
    logic                 r_dacdat;
    logic                 r_underrun;
    logic                 r_overflow;

    logic                 w_bclk_fall;
    logic                 w_lrck_fall;
    logic                 w_lrck_rise;
    logic [31:0]          w_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic [LW-1:0]        w_level;
    logic                 w_fifo_ovf;
    logic signed [31:0]   w_tone_shifted;
    logic [SAMPLE_W-1:0]  w_conv;
    logic [SAMPLE_W-1:0]  w_next_sample;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_bclk_prev <= 1'b0;
            r_lrck_prev <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], bus.AUD_BCLK};
            r_lrck_sync <= {r_lrck_sync[0], bus.AUD_DACLRCK};
            r_bclk_prev <= r_bclk_sync[1];
            r_lrck_prev <= r_lrck_sync[1];
        end
    end

    assign w_bclk_fall = r_bclk_prev & ~r_bclk_sync[1];
    assign w_lrck_fall = r_lrck_prev & ~r_lrck_sync[1];
    assign w_lrck_rise = ~r_lrck_prev & r_lrck_sync[1];

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .i_push     (bus.LD_FIFO),
        .i_wdata    (bus.TONE),
        .i_pop      (w_lrck_fall),
        .o_rdata    (w_rdata),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level),
        .o_overflow (w_fifo_ovf)
    );

    assign w_tone_shifted = $signed(w_rdata) >>> SHIFT;
    assign w_conv         = sat_sample(w_tone_shifted);
    // An empty FIFO at frame start replays the previous sample.
    assign w_next_sample  = w_empty ? r_held : w_conv;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_held   <= '0;
            r_cnt    <= '0;
            r_dacdat <= 1'b0;
        end else if (w_lrck_fall) begin
            r_held  <= w_next_sample;
            r_shift <= w_next_sample;
            r_state <= ST_DELAY;
        end else if (w_lrck_rise && (r_state != ST_IDLE)) begin
            r_shift <= r_held;
            r_state <= ST_DELAY;
        end else if (w_bclk_fall) begin
            case (r_state)
                ST_DELAY: begin
                    r_dacdat <= r_shift[SAMPLE_W-1];
                    r_shift  <= r_shift << 1;
                    r_cnt    <= 5'd1;
                    r_state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_cnt == 5'd16) begin
                        r_dacdat <= 1'b0;
                        r_state  <= ST_PAD;
                    end else begin
                        r_dacdat <= r_shift[SAMPLE_W-1];
                        r_shift  <= r_shift << 1;
                        r_cnt    <= r_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A same-cycle set event wins over CLR_STATUS.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_lrck_fall && w_empty) r_underrun <= 1'b1;
            else if (bus.CLR_STATUS)    r_underrun <= 1'b0;
            if (w_fifo_ovf)             r_overflow <= 1'b1;
            else if (bus.CLR_STATUS)    r_overflow <= 1'b0;
        end
    end

    assign bus.FIFO_FULL  = w_full;
    assign bus.LEVEL      = w_level;
    assign bus.AUD_DACDAT = r_dacdat;
    assign bus.UNDERRUN   = r_underrun;
    assign bus.OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_audio_fifo_i2s.sv
// Directed/randomized bench: drives codec clocks, decodes the I2S stream and
// compares it against a queue-based model of the FIFO and conversion rules.
module tb_audio_fifo_i2s;

    localparam int DEPTH = 16;
    localparam int SHIFT = 8;

    logic clk;
    logic rst_n;

    audio_fifo_i2s_if #(.DEPTH(DEPTH)) bus ();

    audio_fifo_i2s #(
        .DEPTH (DEPTH),
        .SHIFT (SHIFT)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [15:0] held;
    bit          exp_under;
    bit          exp_over;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // floor(t / 2^SHIFT), clamped to the signed 16-bit range
    function automatic logic [15:0] conv(input logic [31:0] t);
        longint v;
        longint s;
        longint d;
        d = longint'(1) << SHIFT;
        v = longint'($signed(t));
        if (v >= 0) s = v / d;
        else        s = -((-v + d - 1) / d);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic push(input logic [31:0] t);
        bus.LD_FIFO = 1'b1;
        bus.TONE    = t;
        tick(1);
        bus.LD_FIFO = 1'b0;
        if (q.size() < DEPTH) q.push_back(t);
        else                  exp_over = 1'b1;
        chk("level_after_push", 32'(bus.LEVEL), 32'(q.size()));
        chk("full_after_push", 32'(bus.FIFO_FULL), 32'(q.size() == DEPTH));
        chk("overflow_after_push", 32'(bus.OVERFLOW), 32'(exp_over));
    endtask

    task automatic clear_status();
        bus.CLR_STATUS = 1'b1;
        tick(1);
        bus.CLR_STATUS = 1'b0;
        exp_under = 1'b0;
        exp_over  = 1'b0;
        chk("underrun_cleared", 32'(bus.UNDERRUN), 32'(0));
        chk("overflow_cleared", 32'(bus.OVERFLOW), 32'(0));
    endtask

    // One channel slot of nper BCLK periods; LRCK changes with the first fall.
    // Data bits are captured at periods 1..16, everything else must be zero.
    task automatic run_half(input logic lr, input int nper, input bit inj,
                            input logic [31:0] inj_tone,
                            output logic [15:0] word, output int pad_ones);
        word     = '0;
        pad_ones = 0;
        for (int p = 0; p < nper; p++) begin
            bus.AUD_BCLK = 1'b0;
            if (p == 0) bus.AUD_DACLRCK = lr;
            if (p == 0 && inj) begin
                // lands in the same CLK cycle as the synchronized LRCK edge
                tick(2);
                bus.LD_FIFO = 1'b1;
                bus.TONE    = inj_tone;
                tick(1);
                bus.LD_FIFO = 1'b0;
                tick(5);
            end else begin
                tick(8);
            end
            bus.AUD_BCLK = 1'b1;
            tick(8);
            if (p >= 1 && p <= 16) word = {word[14:0], bus.AUD_DACDAT};
            else if (bus.AUD_DACDAT !== 1'b0) pad_ones++;
        end
    endtask

    task automatic run_frame(input bit inj, input logic [31:0] inj_tone);
        logic [15:0] w;
        int          pc;
        if (q.size() > 0) held = conv(q.pop_front());
        else              exp_under = 1'b1;
        if (inj) begin
            if (q.size() < DEPTH) q.push_back(inj_tone);
            else                  exp_over = 1'b1;
        end
        run_half(1'b0, 32, inj, inj_tone, w, pc);
        chk("left_word", 32'(w), 32'(held));
        chk("left_pad_zero", 32'(pc), 32'(0));
        chk("level_in_frame", 32'(bus.LEVEL), 32'(q.size()));
        run_half(1'b1, 32, 1'b0, 32'h0, w, pc);
        chk("right_word", 32'(w), 32'(held));
        chk("right_pad_zero", 32'(pc), 32'(0));
        chk("underrun_flag", 32'(bus.UNDERRUN), 32'(exp_under));
        chk("overflow_flag", 32'(bus.OVERFLOW), 32'(exp_over));
    endtask

    initial begin
        logic [15:0] w;
        int          pc;
        logic [31:0] r;
        logic [31:0] t;

        bus.LD_FIFO     = 1'b0;
        bus.TONE        = '0;
        bus.CLR_STATUS  = 1'b0;
        bus.AUD_BCLK    = 1'b1;
        bus.AUD_DACLRCK = 1'b1;
        held      = '0;
        exp_under = 1'b0;
        exp_over  = 1'b0;

        rst_n = 1'b0;
        tick(3);
        chk("reset_level", 32'(bus.LEVEL), 32'(0));
        chk("reset_full", 32'(bus.FIFO_FULL), 32'(0));
        chk("reset_underrun", 32'(bus.UNDERRUN), 32'(0));
        chk("reset_overflow", 32'(bus.OVERFLOW), 32'(0));
        chk("reset_dacdat", 32'(bus.AUD_DACDAT), 32'(0));
        rst_n = 1'b1;
        tick(4);

        // basic word and I2S framing
        push(32'h0001_2300);
        run_frame(1'b0, 32'h0);

        // saturation at both rails
        push(32'h7FFF_FFFF);
        push(32'h8000_0000);
        run_frame(1'b0, 32'h0);
        run_frame(1'b0, 32'h0);

        // randomized amplitudes
        for (int i = 0; i < 6; i++) begin
            r = $urandom();
            case ($urandom_range(2, 0))
                0:       t = r;
                1:       t = {{8{r[23]}}, r[23:0]};
                default: t = {{16{r[15]}}, r[15:0]};
            endcase
            push(t);
        end
        while (q.size() > 0) run_frame(1'b0, 32'h0);

        // fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) push($urandom());
        push(32'hDEAD_BEEF);
        clear_status();

        // push and pop in the same cycle while full
        run_frame(1'b1, 32'h0012_3456);
        while (q.size() > 0) run_frame(1'b0, 32'h0);

        // empty frames repeat the last sample and set UNDERRUN
        for (int i = 0; i < 3; i++) run_frame(1'b0, 32'h0);
        clear_status();
        run_frame(1'b0, 32'h0);

        // push and pop in the same cycle while empty
        clear_status();
        run_frame(1'b1, 32'hFFF1_2345);
        run_frame(1'b0, 32'h0);

        // reset in the middle of a word
        push(32'h0000_FF00);
        held = conv(q.pop_front());
        run_half(1'b0, 9, 1'b0, 32'h0, w, pc);
        bus.AUD_BCLK = 1'b0;
        tick(8);
        bus.AUD_BCLK = 1'b1;
        tick(4);
        chk("bit7_before_reset", 32'(bus.AUD_DACDAT), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("dacdat_in_reset", 32'(bus.AUD_DACDAT), 32'(0));
        chk("level_in_reset", 32'(bus.LEVEL), 32'(0));
        q.delete();
        held      = '0;
        exp_under = 1'b0;
        exp_over  = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        push(32'h0004_560C);
        run_half(1'b1, 32, 1'b0, 32'h0, w, pc);
        chk("idle_right_word", 32'(w), 32'(0));
        chk("idle_right_pad", 32'(pc), 32'(0));
        chk("idle_no_pop", 32'(bus.LEVEL), 32'(1));
        run_frame(1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
